// File: rtl/memwb_stage.sv
// MEM/WB stage with valid/ready handshake, 2-entry skid buffer, flush and saturating stall counter.
// Latency 1 cycle; in_ready depends only on registered state; MEMWB_FWD_EN adds forwarding outputs.
module memwb_stage #(
    parameter int ARQ      = 16,
    parameter int REG_AW   = 4,
    parameter int CNT_W    = 16,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mem_rd_sel,
    input  logic              in_wb_en,
    input  logic [REG_AW-1:0] in_rd_addr,
    input  logic [ARQ-1:0]    in_alu_result,
    input  logic [ARQ-1:0]    in_mem_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic [REG_AW-1:0] out_rd_addr,
    output logic [ARQ-1:0]    out_wb_data,
    output logic [ARQ-1:0]    out_alu_result,
    output logic [CNT_W-1:0]  stall_cnt
`ifdef MEMWB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [ARQ-1:0]    fwd_data
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic              wb_en;
        logic [REG_AW-1:0] rd_addr;
        logic [ARQ-1:0]    wb_data;
        logic [ARQ-1:0]    alu_result;
    } entry_t;

    state_t             state_q, state_d;
    entry_t             head_q, head_d;
    entry_t             skid_q, skid_d;
    entry_t             cap;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic               accept;
    logic               consume;

    assign in_ready = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign accept = in_valid && in_ready;
    assign consume = out_valid && out_ready;

    // Writeback mux and zero-register masking happen at capture so the head is ready to use.
    always_comb begin
        cap            = '0;
        cap.wb_en      = in_wb_en && !((ZERO_REG != 0) && (in_rd_addr == '0));
        cap.rd_addr    = in_rd_addr;
        cap.wb_data    = in_mem_rd_sel ? in_mem_result : in_alu_result;
        cap.alu_result = in_alu_result;
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        head_d  = cap;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        head_d = cap;
                    end else if (accept) begin
                        skid_d  = cap;
                        state_d = FULL;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        head_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        stall_d = stall_q;
        if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    // Head data may be stale after a flush, so the write enable is qualified by valid.
    assign out_wb_en      = head_q.wb_en && out_valid;
    assign out_rd_addr    = head_q.rd_addr;
    assign out_wb_data    = head_q.wb_data;
    assign out_alu_result = head_q.alu_result;
    assign stall_cnt      = stall_q;

`ifdef MEMWB_FWD_EN
    assign fwd_valid = out_valid && out_wb_en;
    assign fwd_addr  = out_rd_addr;
    assign fwd_data  = out_wb_data;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Directed bench for memwb_stage: handshake, skid, flush, zero-register masking, stall saturation.
module tb_memwb_stage;
    localparam int ARQ    = 16;
    localparam int REG_AW = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, flush, in_valid, in_ready, in_mem_rd_sel, in_wb_en;
    logic [REG_AW-1:0] in_rd_addr, out_rd_addr;
    logic [ARQ-1:0]    in_alu_result, in_mem_result, out_wb_data, out_alu_result;
    logic              out_valid, out_ready, out_wb_en;
    logic [CNT_W-1:0]  stall_cnt;
`ifdef MEMWB_FWD_EN
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_addr;
    logic [ARQ-1:0]    fwd_data;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    memwb_stage #(.ARQ(ARQ), .REG_AW(REG_AW), .CNT_W(CNT_W), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mem_rd_sel(in_mem_rd_sel), .in_wb_en(in_wb_en), .in_rd_addr(in_rd_addr),
        .in_alu_result(in_alu_result), .in_mem_result(in_mem_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_wb_en(out_wb_en),
        .out_rd_addr(out_rd_addr), .out_wb_data(out_wb_data),
        .out_alu_result(out_alu_result), .stall_cnt(stall_cnt)
`ifdef MEMWB_FWD_EN
        , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic sel, input logic [3:0] rd, input logic [15:0] alu,
                         input logic [15:0] mem);
        in_valid      = 1'b1;
        in_mem_rd_sel = sel;
        in_wb_en      = 1'b1;
        in_rd_addr    = rd;
        in_alu_result = alu;
        in_mem_result = mem;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mem_rd_sel = 1'b0; in_wb_en = 1'b0;
        in_rd_addr = '0; in_alu_result = '0; in_mem_result = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_wb_en", out_wb_en, 0);
        chk("rst_rd", out_rd_addr, 0);
        chk("rst_data", out_wb_data, 0);
        chk("rst_alu", out_alu_result, 0);
        chk("rst_stall", stall_cnt, 0);
        chk("rst_in_ready", in_ready, 1);

        // single ALU entry, latency 1
        out_ready = 1'b1;
        offer(1'b0, 4'd3, 16'h1234, 16'h9999);
        step();
        in_valid = 1'b0;
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_wb_data, 16'h1234);
        chk("t1_rd", out_rd_addr, 3);
        chk("t1_wb_en", out_wb_en, 1);
        step();
        chk("t1_drain", out_valid, 0);
        chk("t1_wb_en_idle", out_wb_en, 0);

        // memory-select entry
        offer(1'b1, 4'd7, 16'h0001, 16'hBEEF);
        step();
        in_valid = 1'b0;
        chk("t2_data", out_wb_data, 16'hBEEF);
        chk("t2_alu", out_alu_result, 16'h0001);
        step();
        chk("t2_drain", out_valid, 0);

        // backpressure fills the skid
        out_ready = 1'b0;
        offer(1'b0, 4'd1, 16'h0011, 16'h0);
        step();
        chk("t3_ready_one", in_ready, 1);
        chk("t3_stall0", stall_cnt, 0);
        offer(1'b0, 4'd2, 16'h0022, 16'h0);
        step();
        in_valid = 1'b0;
        chk("t3_ready_full", in_ready, 0);
        chk("t3_head_a", out_wb_data, 16'h0011);
        chk("t3_stall1", stall_cnt, 1);
        step();
        chk("t3_stall2", stall_cnt, 2);
        chk("t3_hold_a", out_wb_data, 16'h0011);
        chk("t3_hold_rd", out_rd_addr, 1);
        out_ready = 1'b1;
        step();
        chk("t3_head_b", out_wb_data, 16'h0022);
        chk("t3_b_rd", out_rd_addr, 2);
        chk("t3_b_valid", out_valid, 1);
        chk("t3_ready_after_a", in_ready, 1);
        chk("t3_stall_hold", stall_cnt, 2);
        step();
        chk("t3_drain", out_valid, 0);

        // flush with two held entries and C offered
        out_ready = 1'b0;
        offer(1'b0, 4'd4, 16'h0033, 16'h0);
        step();
        offer(1'b0, 4'd6, 16'h0044, 16'h0);
        step();
        chk("t4_full", in_ready, 0);
        flush = 1'b1;
        offer(1'b0, 4'd8, 16'h0055, 16'h0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("t4_valid", out_valid, 0);
        chk("t4_ready", in_ready, 1);
        chk("t4_wb_en", out_wb_en, 0);
        chk("t4_stall_kept", stall_cnt, 4);
        out_ready = 1'b1;
        step();
        chk("t4_no_c", out_valid, 0);
        step();
        chk("t4_no_c2", out_valid, 0);

        // zero-register masking
        offer(1'b0, 4'd0, 16'h0066, 16'h0);
        step();
        in_valid = 1'b0;
        chk("t5_r0_valid", out_valid, 1);
        chk("t5_r0_wb_en", out_wb_en, 0);
`ifdef MEMWB_FWD_EN
        chk("t5_r0_fwd", fwd_valid, 0);
`endif
        step();
        offer(1'b0, 4'd5, 16'h0077, 16'h0);
        step();
        in_valid = 1'b0;
        chk("t5_r5_wb_en", out_wb_en, 1);
        chk("t5_r5_rd", out_rd_addr, 5);
`ifdef MEMWB_FWD_EN
        chk("t5_r5_fwd", fwd_valid, 1);
        chk("t5_r5_faddr", fwd_addr, 5);
        chk("t5_r5_fdata", fwd_data, 16'h0077);
`endif
        step();

        // saturation, counter starts at 4
        out_ready = 1'b0;
        offer(1'b0, 4'd9, 16'h0088, 16'h0);
        step();
        in_valid = 1'b0;
        chk("t6_start", stall_cnt, 4);
        for (int i = 0; i < 5; i++) step();
        chk("t6_mid", stall_cnt, 9);
        for (int i = 0; i < 15; i++) step();
        chk("t6_sat", stall_cnt, 15);
        chk("t6_hold_data", out_wb_data, 16'h0088);
        rst = 1'b1;
        offer(1'b0, 4'd10, 16'h0099, 16'h0);
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("t6_rst_stall", stall_cnt, 0);
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_ready", in_ready, 1);
        chk("t6_rst_data", out_wb_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
